pong_engine: RTL and testbench

Frame-rate game engine for pong: owns ball position, velocity, collisions and score, and produces the `x_ball`, `y_ball`, `player1_score` and `player2_score` values consumed by the VGA drawing path. It is paced by the per-frame `timing_tick` from `vga_timing`. It takes paddle positions from the player controllers and sits between input handling and `top_vga`.

---
 rtl/pong_pkg.sv | 38 +++
 rtl/pong_collide.sv | 100 ++++++++++
 rtl/pong_engine.sv | 187 ++++++++++++++++++
 tb/tb_pong_engine.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared types and default geometry for the pong game engine and
// the VGA drawing path (draw_ball_pads).
//   pong_state_t    : engine FSM state encoding
//   DEF_*           : default geometry / gameplay constants
//   X_CENTRE/Y_CENTRE : ball serve position (top-left corner)
//   score_inc()     : saturating score increment
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HOLD      = 2'd1,
        PLAY      = 2'd2,
        GAME_OVER = 2'd3
    } pong_state_t;

    localparam int DEF_H_RES        = 1024;
    localparam int DEF_V_RES        = 768;
    localparam int DEF_BALL_SIZE    = 16;
    localparam int DEF_PAD_W        = 16;
    localparam int DEF_PAD_H        = 96;
    localparam int DEF_PAD_X_LEFT   = 32;
    localparam int DEF_PAD_X_RIGHT  = 976;
    localparam int DEF_SPEED        = 4;
    localparam int DEF_WIN_SCORE    = 9;
    localparam int DEF_SERVE_FRAMES = 60;

    function automatic int centre_of(input int res, input int size);
        return (res - size) / 2;
    endfunction

    localparam int X_CENTRE = centre_of(DEF_H_RES, DEF_BALL_SIZE);
    localparam int Y_CENTRE = centre_of(DEF_V_RES, DEF_BALL_SIZE);

    function automatic logic [3:0] score_inc(input logic [3:0] s, input logic [3:0] win);
        return (s >= win) ? win : s + 4'd1;
    endfunction

endpackage

// File: rtl/pong_collide.sv
// pong_collide: combinational one-frame step of the ball.
// Computes the next position from the current position, direction and step
// magnitude, then resolves wall bounces, paddle hits and misses.
//   x_ball, y_ball        : current ball top-left corner
//   dx_neg, dy_neg        : current direction (1 = moving toward 0)
//   step_mag              : pixels moved per frame on each axis
//   y_pad_left/right      : paddle top y
//   x_new, y_new          : resolved position after this frame
//   dx_neg_new, dy_neg_new: resolved direction after this frame
//   paddle_hit            : either paddle returned the ball
//   miss_left/right       : ball passed the left/right edge
module pong_collide
    import pong_pkg::*;
#(
    parameter int H_RES       = DEF_H_RES,
    parameter int V_RES       = DEF_V_RES,
    parameter int BALL_SIZE   = DEF_BALL_SIZE,
    parameter int PAD_W       = DEF_PAD_W,
    parameter int PAD_H       = DEF_PAD_H,
    parameter int PAD_X_LEFT  = DEF_PAD_X_LEFT,
    parameter int PAD_X_RIGHT = DEF_PAD_X_RIGHT
)(
    input  logic [10:0] x_ball,
    input  logic [9:0]  y_ball,
    input  logic        dx_neg,
    input  logic        dy_neg,
    input  logic [3:0]  step_mag,
    input  logic [9:0]  y_pad_left,
    input  logic [9:0]  y_pad_right,
    output logic [10:0] x_new,
    output logic [9:0]  y_new,
    output logic        dx_neg_new,
    output logic        dy_neg_new,
    output logic        paddle_hit,
    output logic        miss_left,
    output logic        miss_right
);

    localparam logic signed [11:0] L_EDGE = 12'(PAD_X_LEFT + PAD_W);
    localparam logic signed [11:0] R_EDGE = 12'(PAD_X_RIGHT - BALL_SIZE);
    localparam logic signed [11:0] X_MAX  = 12'(H_RES - BALL_SIZE);
    localparam logic signed [11:0] Y_MAX  = 12'(V_RES - BALL_SIZE);
    localparam logic signed [11:0] BALL   = 12'(BALL_SIZE);
    localparam logic signed [11:0] PADH   = 12'(PAD_H);

    // 12-bit signed so a step past 0 shows up as a negative value
    logic signed [11:0] x_cur, y_cur, step, x_nxt, y_nxt;
    logic signed [11:0] pad_l_top, pad_r_top;
    logic               overlap_l, overlap_r, hit_l, hit_r;

    always_comb begin
        x_cur     = $signed({1'b0, x_ball});
        y_cur     = $signed({2'b00, y_ball});
        step      = $signed({8'd0, step_mag});
        pad_l_top = $signed({2'b00, y_pad_left});
        pad_r_top = $signed({2'b00, y_pad_right});

        x_nxt = dx_neg ? (x_cur - step) : (x_cur + step);
        y_nxt = dy_neg ? (y_cur - step) : (y_cur + step);

        overlap_l = ((y_cur + BALL) > pad_l_top) && (y_cur < (pad_l_top + PADH));
        overlap_r = ((y_cur + BALL) > pad_r_top) && (y_cur < (pad_r_top + PADH));

        // The ball must start on the open-court side of the paddle face,
        // otherwise a ball already behind the paddle would be pulled back.
        hit_l = dx_neg  && (x_nxt <= L_EDGE) && (x_cur >= L_EDGE) && overlap_l;
        hit_r = !dx_neg && (x_nxt >= R_EDGE) && (x_cur <= R_EDGE) && overlap_r;

        paddle_hit = hit_l || hit_r;
        miss_left  = !hit_l && (x_nxt <= 12'sd0);
        miss_right = !hit_r && (x_nxt >= X_MAX);

        x_new      = x_nxt[10:0];
        dx_neg_new = dx_neg;
        if (hit_l) begin
            x_new      = L_EDGE[10:0];
            dx_neg_new = 1'b0;
        end else if (hit_r) begin
            x_new      = R_EDGE[10:0];
            dx_neg_new = 1'b1;
        end else if (miss_left) begin
            x_new      = 11'd0;
            dx_neg_new = 1'b1;
        end else if (miss_right) begin
            x_new      = X_MAX[10:0];
            dx_neg_new = 1'b0;
        end

        y_new      = y_nxt[9:0];
        dy_neg_new = dy_neg;
        if (y_nxt <= 12'sd0) begin
            y_new      = 10'd0;
            dy_neg_new = 1'b0;
        end else if (y_nxt >= Y_MAX) begin
            y_new      = Y_MAX[9:0];
            dy_neg_new = 1'b1;
        end
    end

endmodule

// File: rtl/pong_engine.sv
// pong_engine: frame-rate pong game engine. Owns ball position, direction,
// step magnitude and scores; advances one frame per timing_tick.
//   clk, rst (sync, active high), timing_tick (1/frame), serve (level)
//   y_pad_left, y_pad_right : paddle top y
//   x_ball, y_ball          : ball top-left corner, registered
//   player1_score/2_score   : left/right scores, registered
//   game_over               : high in GAME_OVER
// Build option PONG_SPEEDUP_EN: each paddle hit adds 1 px to the step, up to
// 2*SPEED; the step returns to SPEED on a miss and on restart.
//
// state     | meaning
// IDLE      | ball centred, waiting for serve
// HOLD      | ball centred, counting SERVE_FRAMES ticks before play
// PLAY      | ball moves one step per tick
// GAME_OVER | ball frozen, serve clears scores and re-serves
module pong_engine
    import pong_pkg::*;
#(
    parameter int H_RES        = DEF_H_RES,
    parameter int V_RES        = DEF_V_RES,
    parameter int BALL_SIZE    = DEF_BALL_SIZE,
    parameter int PAD_W        = DEF_PAD_W,
    parameter int PAD_H        = DEF_PAD_H,
    parameter int PAD_X_LEFT   = DEF_PAD_X_LEFT,
    parameter int PAD_X_RIGHT  = DEF_PAD_X_RIGHT,
    parameter int SPEED        = DEF_SPEED,
    parameter int WIN_SCORE    = DEF_WIN_SCORE,
    parameter int SERVE_FRAMES = DEF_SERVE_FRAMES
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        timing_tick,
    input  logic        serve,
    input  logic [9:0]  y_pad_left,
    input  logic [9:0]  y_pad_right,
    output logic [10:0] x_ball,
    output logic [9:0]  y_ball,
    output logic [3:0]  player1_score,
    output logic [3:0]  player2_score,
    output logic        game_over
);

    localparam int               CNT_W    = $clog2(SERVE_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SERVE_FRAMES);
    localparam logic [10:0]      X_C      = 11'(centre_of(H_RES, BALL_SIZE));
    localparam logic [9:0]       Y_C      = 10'(centre_of(V_RES, BALL_SIZE));
    localparam logic [3:0]       WIN      = 4'(WIN_SCORE);
    localparam logic [3:0]       MAG_BASE = 4'(SPEED);
`ifdef PONG_SPEEDUP_EN
    localparam logic [3:0]       MAG_MAX  = 4'(2 * SPEED);
`else
    localparam logic [3:0]       MAG_MAX  = 4'(SPEED);
`endif

    pong_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       mag_q, mag_d;
    logic             dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
    logic [10:0]      x_d;
    logic [9:0]       y_d;
    logic [3:0]       p1_d, p2_d;

    logic [10:0] col_x;
    logic [9:0]  col_y;
    logic        col_dx_neg, col_dy_neg, col_hit, col_miss_l, col_miss_r;

    pong_collide #(
        .H_RES       (H_RES),
        .V_RES       (V_RES),
        .BALL_SIZE   (BALL_SIZE),
        .PAD_W       (PAD_W),
        .PAD_H       (PAD_H),
        .PAD_X_LEFT  (PAD_X_LEFT),
        .PAD_X_RIGHT (PAD_X_RIGHT)
    ) u_collide (
        .x_ball      (x_ball),
        .y_ball      (y_ball),
        .dx_neg      (dx_neg_q),
        .dy_neg      (dy_neg_q),
        .step_mag    (mag_q),
        .y_pad_left  (y_pad_left),
        .y_pad_right (y_pad_right),
        .x_new       (col_x),
        .y_new       (col_y),
        .dx_neg_new  (col_dx_neg),
        .dy_neg_new  (col_dy_neg),
        .paddle_hit  (col_hit),
        .miss_left   (col_miss_l),
        .miss_right  (col_miss_r)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            mag_q         <= MAG_BASE;
            dx_neg_q      <= 1'b0;
            dy_neg_q      <= 1'b0;
            x_ball        <= X_C;
            y_ball        <= Y_C;
            player1_score <= 4'd0;
            player2_score <= 4'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mag_q         <= mag_d;
            dx_neg_q      <= dx_neg_d;
            dy_neg_q      <= dy_neg_d;
            x_ball        <= x_d;
            y_ball        <= y_d;
            player1_score <= p1_d;
            player2_score <= p2_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mag_d    = mag_q;
        dx_neg_d = dx_neg_q;
        dy_neg_d = dy_neg_q;
        x_d      = x_ball;
        y_d      = y_ball;
        p1_d     = player1_score;
        p2_d     = player2_score;

        case (state_q)
            IDLE: begin
                if (serve) begin
                    state_d = HOLD;
                    cnt_d   = CNT_LOAD;
                end
            end
            HOLD: begin
                if (timing_tick) begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = PLAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            PLAY: begin
                if (timing_tick) begin
                    x_d      = col_x;
                    y_d      = col_y;
                    dx_neg_d = col_dx_neg;
                    dy_neg_d = col_dy_neg;
                    if (col_hit && (mag_q < MAG_MAX))
                        mag_d = mag_q + 4'd1;
                    if (col_miss_l || col_miss_r) begin
                        mag_d = MAG_BASE;
                        if (col_miss_l)
                            p2_d = score_inc(player2_score, WIN);
                        else
                            p1_d = score_inc(player1_score, WIN);
                        // on the winning point the ball stays where it went out
                        if ((col_miss_l && p2_d == WIN) || (col_miss_r && p1_d == WIN)) begin
                            state_d = GAME_OVER;
                        end else begin
                            x_d     = X_C;
                            y_d     = Y_C;
                            state_d = HOLD;
                            cnt_d   = CNT_LOAD;
                        end
                    end
                end
            end
            GAME_OVER: begin
                if (serve) begin
                    p1_d    = 4'd0;
                    p2_d    = 4'd0;
                    mag_d   = MAG_BASE;
                    x_d     = X_C;
                    y_d     = Y_C;
                    state_d = HOLD;
                    cnt_d   = CNT_LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign game_over = (state_q == GAME_OVER);

endmodule

// File: tb/tb_pong_engine.sv
module tb_pong_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        timing_tick = 1'b0;
    logic        serve = 1'b0;
    logic [9:0]  y_pad_left = 10'd200;
    logic [9:0]  y_pad_right = 10'd640;
    logic [10:0] x_ball;
    logic [9:0]  y_ball;
    logic [3:0]  player1_score, player2_score;
    logic        game_over;

    int n_assert = 0;
    int n_fail   = 0;

    pong_engine dut (
        .clk           (clk),
        .rst           (rst),
        .timing_tick   (timing_tick),
        .serve         (serve),
        .y_pad_left    (y_pad_left),
        .y_pad_right   (y_pad_right),
        .x_ball        (x_ball),
        .y_ball        (y_ball),
        .player1_score (player1_score),
        .player2_score (player2_score),
        .game_over     (game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    ticks;
        bit    do_serve;
        int    pad_l;
        int    pad_r;
        int    ex;
        int    ey;
        int    ep1;
        int    ep2;
        int    ego;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input int ticks, input bit do_serve,
                       input int pad_l, input int pad_r, input int ex, input int ey,
                       input int ep1, input int ep2, input int ego);
        vec_t v;
        v.name = name; v.ticks = ticks; v.do_serve = do_serve;
        v.pad_l = pad_l; v.pad_r = pad_r;
        v.ex = ex; v.ey = ey; v.ep1 = ep1; v.ep2 = ep2; v.ego = ego;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input int ex, input int ey,
                             input int ep1, input int ep2, input int ego);
        check({name, ".x"},  int'(x_ball), ex);
        check({name, ".y"},  int'(y_ball), ey);
        check({name, ".p1"}, int'(player1_score), ep1);
        check({name, ".p2"}, int'(player2_score), ep2);
        check({name, ".go"}, int'(game_over), ego);
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) timing_tick = 1'b1;
            @(negedge clk) timing_tick = 1'b0;
        end
    endtask

    task automatic pulse_serve();
        @(negedge clk) serve = 1'b1;
        @(negedge clk) serve = 1'b0;
    endtask

    initial begin
        // Hand-traced rally. Ball steps 4 px/frame, walls at y=0/752,
        // paddle faces at x=48 (left) and x=960 (right), misses at x<=0 / x>=1008.
        add("reset",          0,   0, 200, 640, 504, 376, 0, 0, 0);
        add("idle_ticks",     5,   0, 200, 640, 504, 376, 0, 0, 0);
        add("serve_hold",     0,   1, 200, 640, 504, 376, 0, 0, 0);
        add("hold_59",        59,  0, 200, 640, 504, 376, 0, 0, 0);
        add("hold_60",        1,   0, 200, 640, 504, 376, 0, 0, 0);
        add("first_step",     1,   0, 200, 640, 508, 380, 0, 0, 0);
        add("pre_bottom",     92,  0, 200, 640, 876, 748, 0, 0, 0);
        add("bottom_wall",    1,   0, 200, 640, 880, 752, 0, 0, 0);
        add("after_bottom",   1,   0, 200, 640, 884, 748, 0, 0, 0);
        add("pre_right_hit",  18,  0, 200, 640, 956, 676, 0, 0, 0);
        add("right_hit",      1,   0, 200, 640, 960, 672, 0, 0, 0);
        add("after_r_hit",    1,   0, 200, 640, 956, 668, 0, 0, 0);
        add("top_wall",       167, 0, 200, 640, 288, 0,   0, 0, 0);
        add("after_top",      1,   0, 200, 640, 284, 4,   0, 0, 0);
        add("pre_left_hit",   58,  0, 200, 640, 52,  236, 0, 0, 0);
        add("left_hit",       1,   0, 200, 640, 48,  240, 0, 0, 0);
        add("after_l_hit",    1,   0, 200, 900, 52,  244, 0, 0, 0);
        add("r1_bottom",      127, 0, 200, 900, 560, 752, 0, 0, 0);
        add("r1_edge",        111, 0, 200, 900, 1004, 308, 0, 0, 0);
        add("r1_miss",        1,   0, 200, 900, 504, 376, 1, 0, 0);
        for (int r = 2; r <= 8; r++)
            add($sformatf("r%0d_miss", r), 186, 0, 200, 900, 504, 376, r, 0, 0);
        add("r9_edge",        185, 0, 200, 900, 1004, 628, 8, 0, 0);
        add("game_over",      1,   0, 200, 900, 1008, 624, 9, 0, 1);
        add("frozen",         5,   0, 200, 900, 1008, 624, 9, 0, 1);
        add("restart",        0,   1, 100, 40,  504, 376, 0, 0, 0);
        add("pre_r_hit2",     173, 0, 100, 40,  956, 76,  0, 0, 0);
        add("right_hit2",     1,   0, 100, 40,  960, 80,  0, 0, 0);
        add("pre_left_miss",  239, 0, 100, 40,  4,   468, 0, 0, 0);
        add("left_miss",      1,   0, 100, 40,  504, 376, 0, 1, 0);
        add("serve_left",     62,  0, 100, 40,  496, 368, 0, 1, 0);

        repeat (3) @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            y_pad_left  = 10'(vecs[i].pad_l);
            y_pad_right = 10'(vecs[i].pad_r);
            if (vecs[i].do_serve) pulse_serve();
            do_ticks(vecs[i].ticks);
            check_all(vecs[i].name, vecs[i].ex, vecs[i].ey,
                      vecs[i].ep1, vecs[i].ep2, vecs[i].ego);
        end

        // reset mid-PLAY with a coincident tick: tick must be ignored
        @(negedge clk);
        rst = 1'b1;
        timing_tick = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        timing_tick = 1'b0;
        check_all("rst_mid_play", 504, 376, 0, 0, 0);

        // back in IDLE: ticks alone do nothing
        do_ticks(3);
        check_all("rst_idle", 504, 376, 0, 0, 0);

        // direction restored to +/+ by reset
        y_pad_right = 10'd900;
        pulse_serve();
        do_ticks(61);
        check_all("rst_dir", 508, 380, 0, 0, 0);

        // nothing moves between ticks
        repeat (4) @(negedge clk);
        check("no_tick.x", int'(x_ball), 508);
        check("no_tick.y", int'(y_ball), 380);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
